// File: rtl/thresholding_pkg.sv
// Shared definitions for the thresholding cfg loader.
//   ld_state_t     : loader FSM states
//   CFG_OP_*       : value driven on cfg_we for each op kind
//   cfg_addr_w()   : packed {cf, pe, i} cfg address width
//   csum_step()    : one checksum step, rotl(sum,1) ^ zext(d) over w bits
package thresholding_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_FIN
  } ld_state_t;

  localparam logic CFG_OP_WRITE = 1'b1;
  localparam logic CFG_OP_READ  = 1'b0;

  // Widest checksum the step function supports; callers zero-extend into it.
  localparam int CSUM_MAX_W = 64;

  function automatic int cfg_addr_w(input int n, input int c, input int pe);
    return $clog2(c / pe) + $clog2(pe) + $clog2(n);
  endfunction

  // Operands must already be zero above bit w-1; the result is too.
  function automatic logic [CSUM_MAX_W-1:0] csum_step(
    input logic [CSUM_MAX_W-1:0] sum,
    input logic [CSUM_MAX_W-1:0] d,
    input int                    w
  );
    logic [CSUM_MAX_W-1:0] mask;
    logic [CSUM_MAX_W-1:0] rot;
    mask = (w >= CSUM_MAX_W) ? {CSUM_MAX_W{1'b1}}
                             : ((CSUM_MAX_W'(1) << w) - CSUM_MAX_W'(1));
    rot  = ((sum << 1) | (sum >> (w - 1))) & mask;
    return (rot ^ d) & mask;
  endfunction

endpackage

// File: rtl/thresholding_cfg_addr_seq.sv
// Nested i / pe / cf address counter for the cfg port.
//   clk   : clock
//   clear : restart at {cf,pe,i} = 0 (wins over adv)
//   adv   : step to the next address in channel-major order
//   last  : current address is the final one of a pass
//   addr  : packed {cf, pe, i}; single-valued fields have zero width
module thresholding_cfg_addr_seq #(
  parameter int N   = 3,
  parameter int C   = 4,
  parameter int PE  = 2,
  parameter int A_W = 4
) (
  input  logic           clk,
  input  logic           clear,
  input  logic           adv,
  output logic           last,
  output logic [A_W-1:0] addr
);

  localparam int CF  = C / PE;
  localparam int I_B = $clog2(N);
  localparam int P_B = $clog2(PE);
  localparam int F_B = $clog2(CF);
  localparam int I_W = (I_B > 0) ? I_B : 1;
  localparam int P_W = (P_B > 0) ? P_B : 1;
  localparam int F_W = (F_B > 0) ? F_B : 1;

  logic [I_W-1:0] i_q;
  logic [P_W-1:0] pe_v;
  logic [F_W-1:0] cf_v;
  logic           i_wrap;
  logic           pe_wrap;
  logic           cf_wrap;

  assign i_wrap = (i_q == I_W'(N - 1));

  always_ff @(posedge clk) begin
    if (clear)    i_q <= '0;
    else if (adv) i_q <= i_wrap ? '0 : i_q + I_W'(1);
  end

  generate
    if (PE > 1) begin : g_pe
      logic [P_W-1:0] pe_q;
      always_ff @(posedge clk) begin
        if (clear)              pe_q <= '0;
        else if (adv && i_wrap) pe_q <= pe_wrap ? '0 : pe_q + P_W'(1);
      end
      assign pe_wrap = (pe_q == P_W'(PE - 1));
      assign pe_v    = pe_q;
    end else begin : g_no_pe
      assign pe_wrap = 1'b1;
      assign pe_v    = '0;
    end

    if (CF > 1) begin : g_cf
      logic [F_W-1:0] cf_q;
      always_ff @(posedge clk) begin
        if (clear)                         cf_q <= '0;
        else if (adv && i_wrap && pe_wrap) cf_q <= cf_wrap ? '0 : cf_q + F_W'(1);
      end
      assign cf_wrap = (cf_q == F_W'(CF - 1));
      assign cf_v    = cf_q;
    end else begin : g_no_cf
      assign cf_wrap = 1'b1;
      assign cf_v    = '0;
    end
  endgenerate

  assign last = i_wrap && pe_wrap && cf_wrap;
  // Fields sit at fixed offsets so padding codes (i >= N, pe >= PE) never appear.
  assign addr = A_W'(i_q) | (A_W'(pe_v) << I_B) | (A_W'(cf_v) << (I_B + P_B));

endmodule

// File: rtl/thresholding_cfg_loader.sv
// Loads a channel-major threshold stream into a thresholding datapath through
// its cfg port, then optionally reads the table back and compares checksums.
//   clk, rst          : clock, synchronous active-high reset
//   start/busy/done   : load control; done pulses one cycle at the end
//   err               : sticky checksum mismatch, cleared by the next start
//   s_tvalid/s_tready/s_tdata : threshold stream, c-major, i-minor
//   cfg_en/cfg_we/cfg_a/cfg_d : registered cfg op to the datapath
//   cfg_rack/cfg_q    : readback data, in issue order
module thresholding_cfg_loader
  import thresholding_pkg::*;
#(
  parameter int  K      = 8,
  parameter int  N      = 3,
  parameter int  C      = 4,
  parameter int  PE     = 2,
  parameter int  VERIFY = 1,
  parameter int  CSUM_W = 32,
  localparam int CF     = C / PE,
  localparam int A_W    = cfg_addr_w(N, C, PE)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           err,
  input  logic           s_tvalid,
  output logic           s_tready,
  input  logic [K-1:0]   s_tdata,
  output logic           cfg_en,
  output logic           cfg_we,
  output logic [A_W-1:0] cfg_a,
  output logic [K-1:0]   cfg_d,
  input  logic           cfg_rack,
  input  logic [K-1:0]   cfg_q
);

  localparam int NOPS   = C * N;
  localparam int RCNT_W = $clog2(NOPS + 1);

  generate
    if (CF * PE != C) begin : g_bad_pe
      $error("thresholding_cfg_loader: C must be a multiple of PE");
    end
    if (CSUM_W < K || CSUM_W > CSUM_MAX_W) begin : g_bad_csum
      $error("thresholding_cfg_loader: CSUM_W must lie in [K, 64]");
    end
  endgenerate

  ld_state_t         state_q, state_d;
  logic              load_go, beat, rd_cap;
  logic              op_issue, op_we;
  logic              seq_clr, seq_adv, seq_last;
  logic [A_W-1:0]    seq_addr;
  logic [CSUM_W-1:0] wsum_q, rsum_q;
  logic [RCNT_W-1:0] rcnt_q;

  assign load_go  = (state_q == ST_IDLE) && start;
  assign rd_cap   = cfg_rack && (state_q == ST_READ || state_q == ST_DRAIN);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_FIN);
  assign s_tready = (state_q == ST_WRITE);
  // Restart the address walk for the write pass and again for the read pass.
  assign seq_clr  = load_go || (beat && seq_last);

  thresholding_cfg_addr_seq #(
    .N   (N),
    .C   (C),
    .PE  (PE),
    .A_W (A_W)
  ) u_addr_seq (
    .clk   (clk),
    .clear (seq_clr),
    .adv   (seq_adv),
    .last  (seq_last),
    .addr  (seq_addr)
  );

  always_comb begin
    state_d  = state_q;
    beat     = 1'b0;
    op_issue = 1'b0;
    op_we    = CFG_OP_READ;
    seq_adv  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_WRITE;
      ST_WRITE: begin
        if (s_tvalid) begin
          beat     = 1'b1;
          op_issue = 1'b1;
          op_we    = CFG_OP_WRITE;
          seq_adv  = 1'b1;
          if (seq_last) state_d = (VERIFY != 0) ? ST_READ : ST_FIN;
        end
      end
      ST_READ: begin
        op_issue = 1'b1;
        op_we    = CFG_OP_READ;
        seq_adv  = 1'b1;
        if (seq_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (rcnt_q == RCNT_W'(NOPS)) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---- op issue boundary: control registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cfg_en  <= 1'b0;
      cfg_we  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_en  <= op_issue;
      cfg_we  <= op_issue && op_we;
      if (load_go)
        err <= 1'b0;
      else if (state_q == ST_FIN && VERIFY != 0 && rsum_q != wsum_q)
        err <= 1'b1;
    end
  end

  // ---- op issue boundary: address/data and checksum registers ----
  always_ff @(posedge clk) begin
    if (op_issue) begin
      cfg_a <= seq_addr;
      cfg_d <= s_tdata;
    end
    if (load_go) begin
      wsum_q <= '0;
      rsum_q <= '0;
      rcnt_q <= '0;
    end else begin
      if (beat)
        wsum_q <= CSUM_W'(csum_step(CSUM_MAX_W'(wsum_q), CSUM_MAX_W'(s_tdata), CSUM_W));
      if (rd_cap) begin
        rsum_q <= CSUM_W'(csum_step(CSUM_MAX_W'(rsum_q), CSUM_MAX_W'(cfg_q), CSUM_W));
        rcnt_q <= rcnt_q + RCNT_W'(1);
      end
    end
  end

endmodule
